// File: rtl/lenet_pkg.sv
// Shared LeNet definitions: loader FSM states and default parameter-bank geometry.
// Used by param_loader, the kernel ROM and the convolution units.
package lenet_pkg;

  localparam int PARAM_BIT_WIDTH = 8;
  localparam int PARAM_SIZE      = 26;

  typedef enum logic {
    LOAD = 1'b0,
    DONE = 1'b1
  } loader_state_e;

endpackage

// File: rtl/param_loader.sv
// Streams SIZE parameter words into a register bank and exposes it as a flat vector.
// Define PARAM_LOADER_LAST_CHECK_EN to enable in_last framing checks.
module param_loader
  import lenet_pkg::*;
#(
  parameter int BIT_WIDTH = PARAM_BIT_WIDTH,
  parameter int SIZE      = PARAM_SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIT_WIDTH-1:0]      in_data,
  input  logic                      in_last,
  output logic                      loaded,
  output logic                      err,
  input  logic                      read,
  output logic [BIT_WIDTH*SIZE-1:0] read_out
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

  loader_state_e        state;
  logic [IW-1:0]        idx;
  logic [BIT_WIDTH-1:0] weights [SIZE];
  logic                 accept;
  logic                 at_last;
  logic                 frame_err;

  assign in_ready = (state == LOAD);
  assign loaded   = (state == DONE);
  assign accept   = in_valid && in_ready;
  assign at_last  = (idx == LAST_IDX);

`ifdef PARAM_LOADER_LAST_CHECK_EN
  logic err_q;

  assign frame_err = in_last != at_last;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_q <= 1'b0;
    end else if (accept && frame_err) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_last;

  assign unused_last = in_last;
  assign frame_err   = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      idx   <= '0;
      for (int i = 0; i < SIZE; i++) begin
        weights[i] <= '0;
      end
    end else if (clear) begin
      // Bank contents survive a clear; only sequencing restarts.
      state <= LOAD;
      idx   <= '0;
    end else if (accept) begin
      weights[idx] <= in_data;
      if (frame_err) begin
        idx <= '0;
      end else if (at_last) begin
        idx   <= '0;
        state <= DONE;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Captures the pre-edge bank, so a same-cycle write shows on the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_out <= '0;
    end else if (read) begin
      for (int i = 0; i < SIZE; i++) begin
        read_out[i*BIT_WIDTH +: BIT_WIDTH] <= weights[i];
      end
    end
  end

endmodule

// File: tb/tb_param_loader.sv
// Directed/randomized bench for param_loader against a word-count reference model.
// Covers PARAM_LOADER_LAST_CHECK_EN when the macro is defined.
module tb_param_loader;

  localparam int BW = 8;
  localparam int SZ = 26;
  localparam int RW = BW * SZ;

`ifdef PARAM_LOADER_LAST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          in_last;
  logic          loaded;
  logic          err;
  logic          read;
  logic [RW-1:0] read_out;

  param_loader #(.BIT_WIDTH(BW), .SIZE(SZ)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .loaded   (loaded),
    .err      (err),
    .read     (read),
    .read_out (read_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: words accepted since clear, bank image, captured vector.
  logic [BW-1:0] m_bank [SZ];
  logic [RW-1:0] m_ro;
  int            m_cnt;
  bit            m_done;
  bit            m_err;

  function automatic logic [RW-1:0] pack_bank();
    logic [RW-1:0] v;
    v = '0;
    for (int i = 0; i < SZ; i++) v[i*BW +: BW] = m_bank[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".in_ready"}, 256'(in_ready), 256'(!m_done));
    chk({tag, ".loaded"}, 256'(loaded), 256'(m_done));
    chk({tag, ".err"}, 256'(err), 256'(m_err));
    chk({tag, ".read_out"}, 256'(read_out), 256'(m_ro));
  endtask

  task automatic tick();
    if (rst) begin
      for (int i = 0; i < SZ; i++) m_bank[i] = '0;
      m_ro = '0; m_cnt = 0; m_done = 0; m_err = 0;
    end else begin
      if (read) m_ro = pack_bank();
      if (clear) begin
        m_cnt = 0; m_done = 0; m_err = 0;
      end else if (in_valid && !m_done) begin
        m_bank[m_cnt] = in_data;
        if (CHK && (in_last != (m_cnt == SZ - 1))) begin
          m_cnt = 0; m_err = 1;
        end else if (m_cnt == SZ - 1) begin
          m_cnt = 0; m_done = 1;
        end else begin
          m_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_last = 0; clear = 0; read = 0; rst = 0;
  endtask

  task automatic send(input logic [BW-1:0] w, input bit last, input int gap);
    idle();
    for (int g = 0; g < gap; g++) tick();
    in_valid = 1; in_data = w; in_last = last;
    tick();
    idle();
  endtask

  task automatic do_read();
    idle(); read = 1; tick(); idle();
  endtask

  task automatic do_clear();
    idle(); clear = 1; tick(); idle();
  endtask

  task automatic load_random(input int maxgap);
    for (int i = 0; i < SZ; i++)
      send(BW'($urandom), i == SZ - 1, $urandom_range(0, maxgap));
  endtask

  initial begin
    in_data = '0;
    idle();
    rst = 1;
    tick(); tick();
    idle();
    chk_all("reset");

    // Back-to-back 0x01..0x1A
    for (int i = 0; i < SZ; i++) begin
      send(BW'(i + 1), i == SZ - 1, 0);
      if (i == SZ - 2) chk("pre_last.loaded", 256'(loaded), 256'(0));
    end
    chk_all("b2b_done");
    chk("b2b.loaded", 256'(loaded), 256'(1));
    chk("b2b.in_ready", 256'(in_ready), 256'(0));
    do_read();
    chk("b2b.word0", 256'(read_out[7:0]), 256'h01);
    chk("b2b.word25", 256'(read_out[207:200]), 256'h1A);
    chk_all("b2b_read");

    // Words offered in DONE are ignored
    send(8'hEE, 1'b1, 0);
    do_read();
    chk_all("done_frozen");

    // Random gaps
    do_clear();
    chk_all("clear1");
    load_random(3);
    do_read();
    chk_all("gaps");

    // Clear collides with word 10
    do_clear();
    for (int i = 0; i < 10; i++) send(BW'($urandom), 1'b0, 0);
    in_valid = 1; in_data = 8'h5A; clear = 1;
    tick();
    idle();
    chk_all("clear_drop");
    load_random(1);
    do_read();
    chk_all("reload");

    // Reset mid-load
    do_clear();
    for (int i = 0; i < 13; i++) send(BW'($urandom), 1'b0, 0);
    rst = 1; tick(); idle();
    chk_all("rst_mid");
    chk("rst_mid.read_out", 256'(read_out), 256'(0));
    do_read();
    chk("rst_read.read_out", 256'(read_out), 256'(0));

    // Read collides with write of word 5
    for (int i = 0; i < 5; i++) send(BW'($urandom), 1'b0, 0);
    in_valid = 1; in_data = 8'hAA; in_last = 0; read = 1;
    tick();
    idle();
    chk("rw.old_word5", 256'(read_out[5*BW +: BW]), 256'h00);
    do_read();
    chk("rw.new_word5", 256'(read_out[5*BW +: BW]), 256'hAA);
    chk_all("rw");

`ifdef PARAM_LOADER_LAST_CHECK_EN
    do_clear();
    for (int i = 0; i < 20; i++) send(BW'($urandom), 1'b0, 0);
    send(8'h33, 1'b1, 0);
    chk_all("last_err");
    chk("last_err.err", 256'(err), 256'(1));
    load_random(1);
    chk_all("after_err_load");
    chk("after_err.loaded", 256'(loaded), 256'(1));
    do_read();
    chk_all("after_err_read");
    do_clear();
    chk("err_cleared", 256'(err), 256'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
